morse_keyer_sequencer: RTL

Sequences one Morse character at a time onto a single keying line. Accepts character requests (A-Z as 0-25, or a word-space) over a valid/ready handshake and drives the code of the current character to the external `morse_encoder` ROM. It latches the returned length and pattern, then plays dots, dashes and gaps with standard unit timing. It sits between the text/character source and the tone or LED driver.

---
 rtl/morse_keyer_sequencer_if.sv | 26 ++
 rtl/morse_keyer_sequencer.sv | 135 +++++++++++++
 2 files changed

// File: rtl/morse_keyer_sequencer_if.sv
// Character request handshake, encoder ROM lookup and keying outputs of the
// Morse keyer sequencer, bundled as one interface.
interface morse_keyer_sequencer_if;
    logic       char_valid;
    logic       char_ready;
    logic [4:0] char_code;
    logic       char_space;
    logic [4:0] rom_char_code;
    logic [2:0] rom_len;
    logic [4:0] rom_pattern;
    logic       key_out;
    logic       busy;
    logic       char_done;

    // Character source plus encoder ROM side
    modport master (
        output char_valid, char_code, char_space, rom_len, rom_pattern,
        input  char_ready, rom_char_code, key_out, busy, char_done
    );

    // Sequencer side
    modport slave (
        input  char_valid, char_code, char_space, rom_len, rom_pattern,
        output char_ready, rom_char_code, key_out, busy, char_done
    );
endinterface

// File: rtl/morse_keyer_sequencer.sv
// Plays one Morse character (or a word-space) at a time onto a keying line,
// using the external encoder ROM for symbol length and dot/dash pattern.
module morse_keyer_sequencer #(
    parameter int unsigned UNIT_CYCLES = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    morse_keyer_sequencer_if.slave   bus
);

    localparam int unsigned CNT_W = $clog2(4 * UNIT_CYCLES + 1);
    localparam logic [CNT_W-1:0] DOT_M1  = CNT_W'(UNIT_CYCLES - 1);
    localparam logic [CNT_W-1:0] DASH_M1 = CNT_W'(3 * UNIT_CYCLES - 1);
    localparam logic [CNT_W-1:0] WORD_M1 = CNT_W'(4 * UNIT_CYCLES - 1);

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_LOAD = 3'd1,
        S_MARK = 3'd2,
        S_SGAP = 3'd3,
        S_CGAP = 3'd4,
        S_WGAP = 3'd5
    } state_t;

    state_t             r_state;
    logic [4:0]         r_pat;
    logic [2:0]         r_rem;
    logic [CNT_W-1:0]   r_cnt;
    logic [4:0]         r_code;
    logic               r_key;
    logic               r_ready;
    logic               r_done;

    logic [2:0]         w_len;
    logic [2:0]         w_rem_dec;
    logic [4:0]         w_pat_shift;
    logic               w_cnt_zero;

    // ROM length clamped into the playable 1..5 symbol range
    always_comb begin
        w_len = bus.rom_len;
        if (bus.rom_len == 3'd0) begin
            w_len = 3'd1;
        end else if (bus.rom_len > 3'd5) begin
            w_len = 3'd5;
        end
    end

    assign w_rem_dec   = r_rem - 3'd1;
    assign w_pat_shift = r_pat >> 1;
    assign w_cnt_zero  = (r_cnt == '0);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
            r_pat   <= '0;
            r_rem   <= '0;
            r_cnt   <= '0;
            r_code  <= '0;
            r_key   <= 1'b0;
            r_ready <= 1'b1;
            r_done  <= 1'b0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (bus.char_valid) begin
                        r_ready <= 1'b0;
                        if (bus.char_space) begin
                            r_state <= S_WGAP;
                            r_cnt   <= WORD_M1;
                        end else begin
                            r_code  <= bus.char_code;
                            r_state <= S_LOAD;
                        end
                    end
                end
                S_LOAD: begin
                    r_pat   <= bus.rom_pattern;
                    r_rem   <= w_len;
                    r_cnt   <= bus.rom_pattern[0] ? DASH_M1 : DOT_M1;
                    r_key   <= 1'b1;
                    r_state <= S_MARK;
                end
                S_MARK: begin
                    if (w_cnt_zero) begin
                        r_pat <= w_pat_shift;
                        r_rem <= w_rem_dec;
                        r_key <= 1'b0;
                        if (w_rem_dec == 3'd0) begin
                            r_state <= S_CGAP;
                            r_cnt   <= DASH_M1;
                        end else begin
                            r_state <= S_SGAP;
                            r_cnt   <= DOT_M1;
                        end
                    end else begin
                        r_cnt <= r_cnt - CNT_W'(1);
                    end
                end
                S_SGAP: begin
                    // pat was shifted on MARK exit, so bit 0 is the next symbol
                    if (w_cnt_zero) begin
                        r_state <= S_MARK;
                        r_key   <= 1'b1;
                        r_cnt   <= r_pat[0] ? DASH_M1 : DOT_M1;
                    end else begin
                        r_cnt <= r_cnt - CNT_W'(1);
                    end
                end
                S_CGAP, S_WGAP: begin
                    if (w_cnt_zero) begin
                        r_state <= S_IDLE;
                        r_ready <= 1'b1;
                        r_done  <= 1'b1;
                    end else begin
                        r_cnt <= r_cnt - CNT_W'(1);
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                    r_ready <= 1'b1;
                    r_key   <= 1'b0;
                end
            endcase
        end
    end

    assign bus.char_ready    = r_ready;
    assign bus.busy          = ~r_ready;
    assign bus.rom_char_code = r_code;
    assign bus.key_out       = r_key;
    assign bus.char_done     = r_done;

endmodule
